// File: rtl/fixed_point_sqrt_arbiter.sv
// Round-robin arbiter in front of one shared restoring square-root engine (one root bit per clock).
// Optional macro FP_SQRT_ARB_ROUND_EN adds a guard-bit cycle and round-half-up with saturation.
module fixed_point_sqrt_arbiter #(
    parameter int WII  = 8,
    parameter int WIF  = 8,
    parameter int NREQ = 3,
    localparam int WRI = (WII + 1) / 2,
    localparam int NB  = WRI + WIF,
    localparam int WO  = WRI + 1 + WIF,
    localparam int WID = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int IW  = WII + WIF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      in_valid,
    output logic [NREQ-1:0]      in_ready,
    input  logic [NREQ*IW-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WO-1:0]        out_data,
    output logic [WID-1:0]       out_id,
    output logic                 busy
);

`ifdef FP_SQRT_ARB_ROUND_EN
    typedef enum logic [1:0] {IDLE, CALC, EXTRA, DONE} state_t;
    localparam int RTW = NB + 1;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int RTW = NB;
`endif

    localparam int OPW = 2 * NB;
    localparam int RW  = NB + 3;
    localparam int CW  = $clog2(NB + 1);

    state_t           state, state_next;
    logic [WID-1:0]   ptr, id, grant;
    logic             grant_valid;
    logic             sign;
    logic [OPW-1:0]   op, op_init;
    logic [RW-1:0]    rem, rem_shift, rem_next, test;
    logic [RTW-1:0]   root, root_next;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    x, x_mag;
    logic [NB-1:0]    mag;
    logic [WO-1:0]    result;
    logic             step;
    int               idx;

    // Search for the first valid requester starting at ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!grant_valid && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = WID'(idx);
            end
        end
    end

    always_comb begin
        x       = in_data[int'(grant)*IW +: IW];
        x_mag   = x[IW-1] ? (~x + 1'b1) : x;
        op_init = '0;
        op_init[IW+WIF-1:WIF] = x_mag;
    end

    // One restoring recurrence step: bring down two operand bits, try subtracting 4*root+1.
    always_comb begin
        rem_shift = (rem << 2) | {{(RW-2){1'b0}}, op[OPW-1 -: 2]};
        test      = RW'({root, 2'b01});
        if (rem_shift >= test) begin
            rem_next  = rem_shift - test;
            root_next = (root << 1) | {{(RTW-1){1'b0}}, 1'b1};
        end else begin
            rem_next  = rem_shift;
            root_next = root << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        step       = 1'b0;
        busy       = (state != IDLE);
        out_valid  = 1'b0;
        in_ready   = '0;
        case (state)
            IDLE: begin
                if (grant_valid && !rst) begin
                    in_ready[grant] = 1'b1;
                    state_next      = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == '0) begin
`ifdef FP_SQRT_ARB_ROUND_EN
                    state_next = EXTRA;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef FP_SQRT_ARB_ROUND_EN
            EXTRA: begin
                step       = 1'b1;
                state_next = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            id   <= '0;
            sign <= 1'b0;
            op   <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (state == IDLE && grant_valid) begin
            sign <= x[IW-1];
            op   <= op_init;
            rem  <= '0;
            root <= '0;
            cnt  <= CW'(NB - 1);
            id   <= grant;
            ptr  <= (grant == WID'(NREQ - 1)) ? '0 : grant + 1'b1;
        end else if (step) begin
            op   <= op << 2;
            rem  <= rem_next;
            root <= root_next;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef FP_SQRT_ARB_ROUND_EN
    logic [NB:0] rsum;
    // root holds 2r+g; round half-up and clamp to NB bits.
    always_comb begin
        rsum = {1'b0, root[NB:1]} + {{NB{1'b0}}, root[0]};
        mag  = rsum[NB] ? '1 : rsum[NB-1:0];
    end
`else
    always_comb begin
        mag = root;
    end
`endif

    always_comb begin
        result   = sign ? -{1'b0, mag} : {1'b0, mag};
        out_data = (state == DONE) ? result : '0;
        out_id   = (state == DONE) ? id : '0;
    end

endmodule

// File: tb/tb_fixed_point_sqrt_arbiter.sv
// Self-checking bench for fixed_point_sqrt_arbiter (WII=8, WIF=8, NREQ=3) against an arithmetic sqrt model.
module tb_fixed_point_sqrt_arbiter;
    localparam int NREQ = 3;
    localparam int IW   = 16;
    localparam int NB   = 12;
`ifdef FP_SQRT_ARB_ROUND_EN
    localparam int LAT = NB + 1;
`else
    localparam int LAT = NB;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid = '0;
    logic [2:0]  in_ready;
    logic [47:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] out_data;
    logic [1:0]  out_id;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fixed_point_sqrt_arbiter #(.WII(8), .WIF(8), .NREQ(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    function automatic longint isqrt(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Expected result: value of x (Q8.8) -> sqrt of |x| scaled to Q.8, sign reapplied, 13-bit two's complement.
    function automatic logic [12:0] ref_sqrt(input logic [15:0] x);
        longint v, r;
        bit neg;
        neg = x[15];
        v = neg ? (65536 - longint'(x)) : longint'(x);
        v = v * 256;
`ifdef FP_SQRT_ARB_ROUND_EN
        r = (isqrt(v * 4) + 1) / 2;
        if (r > 4095) r = 4095;
`else
        r = isqrt(v);
`endif
        return neg ? 13'(-r) : 13'(r);
    endfunction

    task automatic run_one(input int k, input logic [15:0] data, output logic [2:0] rdy,
                           output logic [12:0] rdata, output logic [1:0] rid, output int lat);
        @(negedge clk);
        in_data[k*IW +: IW] = data;
        in_valid = '0;
        in_valid[k] = 1'b1;
        #1 rdy = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rdata = out_data;
        rid   = out_id;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 3'b000) begin fails++; $display("[TB] FAIL reset_in_ready got=%b want=000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 13'h0) begin fails++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (out_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_out_id got=%0d want=0", out_id); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int          ks[6] = '{0, 1, 2, 0, 1, 2};
        logic [15:0] ds[6] = '{16'h0400, 16'h0200, 16'h0003, 16'hF700, 16'h8000, 16'h0000};
        logic [2:0]  rdy;
        logic [12:0] rdata, exp;
        logic [1:0]  rid;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_one(ks[i], ds[i], rdy, rdata, rid, lat);
            exp = ref_sqrt(ds[i]);
            checks++; if (rdy !== 3'(1 << ks[i])) begin fails++; $display("[TB] FAIL directed_ready[%0d] got=%b want=%b", i, rdy, 3'(1 << ks[i])); end
            checks++; if (rdata !== exp) begin fails++; $display("[TB] FAIL directed_data[%0d] in=%h got=%h want=%h", i, ds[i], rdata, exp); end
            checks++; if (rid !== 2'(ks[i])) begin fails++; $display("[TB] FAIL directed_id[%0d] got=%0d want=%0d", i, rid, ks[i]); end
            checks++; if (lat != LAT) begin fails++; $display("[TB] FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  rdy;
        logic [12:0] rdata, exp;
        logic [1:0]  rid;
        int          lat, k;
        logic [15:0] d;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 2);
            d = 16'($urandom);
            run_one(k, d, rdy, rdata, rid, lat);
            exp = ref_sqrt(d);
            checks++; if (rdata !== exp) begin fails++; $display("[TB] FAIL random_data[%0d] in=%h got=%h want=%h", i, d, rdata, exp); end
            checks++; if (rid !== 2'(k)) begin fails++; $display("[TB] FAIL random_id[%0d] got=%0d want=%0d", i, rid, k); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d[3] = '{16'h1234, 16'hFF00, 16'h7FFF};
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        int grants = 0, results = 0;
        int pulses[3] = '{0, 0, 0};
        logic [12:0] exp;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) in_data[k*IW +: IW] = d[k];
        in_valid = 3'b111;
        for (int cyc = 0; cyc < 300 && results < 6; cyc++) begin
            #1;
            if (in_ready !== 3'b000) begin
                checks++;
                if (grants >= 6 || in_ready !== 3'(1 << exp_order[grants])) begin
                    fails++; $display("[TB] FAIL b2b_grant[%0d] got=%b", grants, in_ready);
                end
                for (int k = 0; k < 3; k++) pulses[k] += int'(in_ready[k]);
                grants++;
            end
            if (out_valid) begin
                exp = (results < 6) ? ref_sqrt(d[exp_order[results]]) : 13'h0;
                checks++;
                if (results >= 6 || out_id !== 2'(exp_order[results]) || out_data !== exp) begin
                    fails++; $display("[TB] FAIL b2b_result[%0d] got id=%0d data=%h want data=%h", results, out_id, out_data, exp);
                end
                results++;
            end
            @(posedge clk);
            @(negedge clk);
            if (grants >= 6) in_valid = '0;
        end
        in_valid = '0;
        checks++; if (results != 6) begin fails++; $display("[TB] FAIL b2b_result_count got=%0d want=6", results); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (pulses[k] != 2) begin fails++; $display("[TB] FAIL b2b_pulses[%0d] got=%0d want=2", k, pulses[k]); end
        end
    endtask

    task automatic test_stall();
        logic [2:0]  rdy;
        logic [12:0] rdata, exp;
        logic [1:0]  rid;
        int          lat;
        out_ready = 1'b0;
        exp = ref_sqrt(16'h0900);
        run_one(1, 16'h0900, rdy, rdata, rid, lat);
        checks++; if (rdata !== exp || rid !== 2'd1) begin fails++; $display("[TB] FAIL stall_first got id=%0d data=%h want id=1 data=%h", rid, rdata, exp); end
        in_data[0 +: IW] = 16'h0100;
        in_valid = 3'b001;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_id !== 2'd1 || in_ready !== 3'b000) begin
                fails++; $display("[TB] FAIL stall_hold[%0d] got valid=%b data=%h id=%0d ready=%b want valid=1 data=%h id=1 ready=000",
                                  i, out_valid, out_data, out_id, in_ready, exp);
            end
        end
        in_valid = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL stall_release got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_abort();
        int seen = 0, n;
        logic [12:0] exp;
        @(negedge clk);
        in_data[1*IW +: IW] = 16'h0400;
        in_valid = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_valid = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 13'h0 || out_id !== 2'd0 || in_ready !== 3'b000) begin
            fails++; $display("[TB] FAIL abort_reset got busy=%b valid=%b data=%h id=%0d ready=%b want all zero",
                              busy, out_valid, out_data, out_id, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("[TB] FAIL abort_no_output got=%0d want=0", seen); end
        // With ptr back at 0, requester 0 wins over requester 2.
        in_data[0*IW +: IW] = 16'h0100;
        in_data[2*IW +: IW] = 16'h0003;
        in_valid = 3'b101;
        #1;
        checks++; if (in_ready !== 3'b001) begin fails++; $display("[TB] FAIL abort_ptr_reset got=%b want=001", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 3'b100;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
        exp = ref_sqrt(16'h0100);
        #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== exp) begin fails++; $display("[TB] FAIL abort_req0 got id=%0d data=%h want id=0 data=%h", out_id, out_data, exp); end
        checks++; if (in_ready !== 3'b000) begin fails++; $display("[TB] FAIL abort_same_cycle_grant got=%b want=000", in_ready); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 3'b100) begin fails++; $display("[TB] FAIL abort_req2_grant got=%b want=100", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = '0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
        exp = ref_sqrt(16'h0003);
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== exp) begin fails++; $display("[TB] FAIL abort_req2 got id=%0d data=%h want id=2 data=%h", out_id, out_data, exp); end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_stall();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
